// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt arbiter.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        BUSY
    } arb_state_t;

    localparam int unsigned IRQ_NUM_DEFAULT = 8;

    // Smallest width able to hold ids 0..n-1 (n >= 2).
    function automatic int unsigned irq_id_width(input int unsigned n);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/irq_prio_select.sv
// Combinational winner search: first eligible bit at or after i_start, wrapping.
module irq_prio_select
    import irq_pkg::*;
#(
    parameter int unsigned NUM_IRQ = IRQ_NUM_DEFAULT,
    parameter int unsigned ID_W    = irq_id_width(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] i_eligible,
    input  logic [ID_W-1:0]    i_start,
    output logic               o_found,
    output logic [ID_W-1:0]    o_id
);

    int unsigned        w_idx;
    logic [NUM_IRQ-1:0] w_shift;

    always_comb begin
        o_found = 1'b0;
        o_id    = '0;
        w_idx   = 0;
        w_shift = '0;
        for (int unsigned k = 0; k < NUM_IRQ; k++) begin
            w_idx = 32'(i_start) + k;
            if (w_idx >= NUM_IRQ) begin
                w_idx = w_idx - NUM_IRQ;
            end
            w_shift = i_eligible >> w_idx;
            if (!o_found && w_shift[0]) begin
                o_found = 1'b1;
                o_id    = ID_W'(w_idx);
            end
        end
    end

endmodule

// File: rtl/irq_sync2.sv
// Two-flop synchroniser for a single asynchronous input bit.
module irq_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/irq_arbiter.sv
// Multi-source interrupt arbiter with claim/complete handshake.
// Define IRQ_ARB_RR_EN for round-robin selection; default is fixed priority (lowest id wins).
module irq_arbiter
    import irq_pkg::*;
#(
    parameter int unsigned NUM_IRQ = IRQ_NUM_DEFAULT,
    parameter int unsigned ID_W    = irq_id_width(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               en_we,
    input  logic [NUM_IRQ-1:0] en_wdata,
    output logic [NUM_IRQ-1:0] en_o,
    output logic [NUM_IRQ-1:0] pending_o,
    output logic               irq_req,
    input  logic               claim,
    output logic               claim_ack,
    output logic               claim_valid,
    output logic [ID_W-1:0]    claim_id,
    input  logic               complete,
    input  logic [ID_W-1:0]    complete_id
);

    logic [NUM_IRQ-1:0] w_sync;
    logic [NUM_IRQ-1:0] w_edge;
    logic [NUM_IRQ-1:0] w_eligible;
    logic [NUM_IRQ-1:0] w_clr;
    logic [NUM_IRQ-1:0] r_prev;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_en;
    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic               w_found;
    logic [ID_W-1:0]    w_win;
    logic [ID_W-1:0]    w_start;
    logic               w_grant;
    logic               r_ack;
    logic               r_valid;
    logic [ID_W-1:0]    r_id;
    logic [ID_W-1:0]    w_id_nxt;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IRQ; gi++) begin : g_sync
            irq_sync2 u_sync (
                .clk   (clk),
                .rst_n (rst_n),
                .i_d   (irq_i[gi]),
                .o_q   (w_sync[gi])
            );
        end
    endgenerate

    assign w_edge     = w_sync & ~r_prev;
    assign w_eligible = r_pending & r_en;

`ifdef IRQ_ARB_RR_EN
    logic [ID_W-1:0] r_ptr;

    assign w_start = (r_ptr == ID_W'(NUM_IRQ - 1)) ? '0 : r_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= ID_W'(NUM_IRQ - 1);
        end else if (w_grant) begin
            r_ptr <= w_win;
        end
    end
`else
    assign w_start = '0;
`endif

    irq_prio_select #(
        .NUM_IRQ (NUM_IRQ),
        .ID_W    (ID_W)
    ) u_sel (
        .i_eligible (w_eligible),
        .i_start    (w_start),
        .o_found    (w_found),
        .o_id       (w_win)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_id_nxt    = '0;
        case (r_state)
            IDLE: begin
                if (|w_eligible) begin
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (!w_found) begin
                    w_state_nxt = IDLE;
                end else if (claim) begin
                    w_grant     = 1'b1;
                    w_id_nxt    = w_win;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (complete && (complete_id == r_id)) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_id_nxt = r_id;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // A fresh edge on the granted line re-sets its bit, so it wins over the clear.
    assign w_clr = w_grant ? (NUM_IRQ'(1) << w_win) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev    <= '0;
            r_pending <= '0;
            r_en      <= '0;
            r_state   <= IDLE;
            r_ack     <= 1'b0;
            r_valid   <= 1'b0;
            r_id      <= '0;
        end else begin
            r_prev    <= w_sync;
            r_pending <= (r_pending & ~w_clr) | w_edge;
            if (en_we) begin
                r_en <= en_wdata;
            end
            r_state   <= w_state_nxt;
            r_ack     <= claim;
            r_valid   <= w_grant;
            r_id      <= w_id_nxt;
        end
    end

    assign en_o        = r_en;
    assign pending_o   = r_pending;
    assign irq_req     = (r_state == REQ);
    assign claim_ack   = r_ack;
    assign claim_valid = r_valid;
    assign claim_id    = r_id;

endmodule

// File: tb/tb_irq_arbiter.sv
// Scoreboard bench for irq_arbiter: claim responses are queued when issued and checked by a monitor.
module tb_irq_arbiter;

    localparam int unsigned N  = 8;
    localparam int unsigned IW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  irq_i;
    logic          en_we;
    logic [N-1:0]  en_wdata;
    logic [N-1:0]  en_o;
    logic [N-1:0]  pending_o;
    logic          irq_req;
    logic          claim;
    logic          claim_ack;
    logic          claim_valid;
    logic [IW-1:0] claim_id;
    logic          complete;
    logic [IW-1:0] complete_id;

    typedef struct {
        logic          v;
        logic [IW-1:0] id;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;

    irq_arbiter #(.NUM_IRQ(N), .ID_W(IW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .irq_i       (irq_i),
        .en_we       (en_we),
        .en_wdata    (en_wdata),
        .en_o        (en_o),
        .pending_o   (pending_o),
        .irq_req     (irq_req),
        .claim       (claim),
        .claim_ack   (claim_ack),
        .claim_valid (claim_valid),
        .claim_id    (claim_id),
        .complete    (complete),
        .complete_id (complete_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_claim(input logic v, input logic [IW-1:0] id);
        exp_t e;
        e.v  = v;
        e.id = id;
        q.push_back(e);
        claim = 1'b1;
        tick();
        claim = 1'b0;
    endtask

    task automatic do_complete(input logic [IW-1:0] id);
        complete    = 1'b1;
        complete_id = id;
        tick();
        complete    = 1'b0;
        complete_id = '0;
    endtask

    task automatic set_en(input logic [N-1:0] v);
        en_we    = 1'b1;
        en_wdata = v;
        tick();
        en_we    = 1'b0;
    endtask

    // Monitor: every claim_ack pulse must match the oldest queued expectation.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (claim_ack) begin
            n_chk++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected_ack: got valid=%0b id=%0d expected no ack at %0t",
                         claim_valid, claim_id, $time);
            end else begin
                e = q.pop_front();
                if ({claim_valid, claim_id} !== {e.v, e.id}) begin
                    n_err++;
                    $display("FAIL sb_claim: got valid=%0b id=%0d expected valid=%0b id=%0d at %0t",
                             claim_valid, claim_id, e.v, e.id, $time);
                end
            end
        end
    end

    logic [IW-1:0] rr_exp;

    initial begin
        rst_n = 1'b0; irq_i = '0; en_we = 1'b0; en_wdata = '0;
        claim = 1'b0; complete = 1'b0; complete_id = '0;
        tick(3);
        chk("rst_en", en_o, 0);
        chk("rst_pending", pending_o, 0);
        chk("rst_outs", {irq_req, claim_ack, claim_valid, claim_id}, 0);
        rst_n = 1'b1;
        tick();

        // 1: single source, exact request latency
        set_en(8'hFF);
        chk("t1_en", en_o, 8'hFF);
        irq_i = 8'h08;
        tick(3);
        chk("t1_pending", pending_o, 8'h08);
        chk("t1_req_early", irq_req, 0);
        tick();
        chk("t1_req", irq_req, 1);
        do_claim(1'b1, 3'd3);
        chk("t1_pend_clr", pending_o, 8'h00);
        chk("t1_busy_req", irq_req, 0);
        irq_i = '0;
        do_complete(3'd3);
        tick(2);
        chk("t1_idle_req", irq_req, 0);

        // 2: fixed priority between two simultaneous sources
        irq_i = 8'h24;
        tick(4);
        chk("t2_pending", pending_o, 8'h24);
        chk("t2_req", irq_req, 1);
`ifdef IRQ_ARB_RR_EN
        rr_exp = 3'd5;
`else
        rr_exp = 3'd2;
`endif
        do_claim(1'b1, rr_exp);
        chk("t2_busy_req", irq_req, 0);
        do_complete(rr_exp);
        tick();
        chk("t2_req_again", irq_req, 1);
        do_claim(1'b1, (rr_exp == 3'd2) ? 3'd5 : 3'd2);
        do_complete((rr_exp == 3'd2) ? 3'd5 : 3'd2);
        irq_i = '0;
        tick(3);

        // 3: masked line latches pending but does not request
        set_en(8'h00);
        irq_i = 8'h02;
        tick(6);
        chk("t3_pending", pending_o, 8'h02);
        chk("t3_masked_req", irq_req, 0);
        set_en(8'h02);
        chk("t3_req_lag", irq_req, 0);
        tick();
        chk("t3_req", irq_req, 1);
        do_claim(1'b1, 3'd1);
        do_complete(3'd1);
        irq_i = '0;
        set_en(8'hFF);
        tick(3);

        // 4: wrong-id completion ignored, claim outside REQ
        irq_i = 8'h10;
        tick(4);
        chk("t4_req", irq_req, 1);
        do_claim(1'b1, 3'd4);
        do_complete(3'd6);
        chk("t4_still_busy", irq_req, 0);
        chk("t4_id_held", claim_id, 4);
        do_claim(1'b0, 3'd4);
        do_complete(3'd4);
        do_claim(1'b0, 3'd0);
        tick();
        chk("t4_idle_req", irq_req, 0);
        irq_i = '0;
        tick(3);

        // 5: new edge on line 0 in the same cycle as its grant
        irq_i = 8'h01;
        tick(4);
        chk("t5_req", irq_req, 1);
        irq_i = 8'h00;
        tick(3);
        irq_i = 8'h01;
        tick(2);
        do_claim(1'b1, 3'd0);
        chk("t5_pend_kept", pending_o, 8'h01);
        chk("t5_busy_req", irq_req, 0);
        do_complete(3'd0);
        tick();
        chk("t5_req_after", irq_req, 1);
        do_claim(1'b1, 3'd0);
        do_complete(3'd0);
        irq_i = '0;
        tick(3);

        // 6: repeated re-firing of lines 0 and 1, then reset while BUSY
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        set_en(8'hFF);
        irq_i = 8'h03;
        tick(4);
        for (int i = 0; i < 4; i++) begin
`ifdef IRQ_ARB_RR_EN
            rr_exp = IW'(i % 2);
`else
            rr_exp = 3'd0;
`endif
            do_claim(1'b1, rr_exp);
            irq_i = '0;
            tick(3);
            do_complete(rr_exp);
            irq_i = 8'h03;
            tick(4);
            chk("t6_req", irq_req, 1);
        end
        do_claim(1'b1, 3'd0);
        chk("t6_busy", irq_req, 0);
        rst_n = 1'b0;
        tick();
        chk("t6_rst_en", en_o, 0);
        chk("t6_rst_pending", pending_o, 0);
        chk("t6_rst_outs", {irq_req, claim_ack, claim_valid, claim_id}, 0);
        rst_n = 1'b1;
        irq_i = '0;
        tick(2);
        #2;
        chk("sb_drain", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
